// File: rtl/spi_mem_arbiter.sv
// Two-port round-robin arbiter in front of a serial (SPI-style) memory slave.
// Each grant runs one framed write or read and ends in a one-cycle ack pulse.
module spi_mem_arbiter #(
  parameter int MEM_DEPTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [1:0]  ack_o,
  output logic [7:0]  rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_ready_i,
  input  logic        spi_op_done_i,
  input  logic        spi_miso_i
);

  localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    SHIFT_OUT  = 3'd2,
    WAIT_READY = 3'd3,
    SHIFT_IN   = 3'd4,
    WAIT_DONE  = 3'd5,
    RESP       = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     frame_q, frame_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic [7:0]      sh_q, sh_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic [1:0]      ack_q, ack_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            busy_q, busy_d;

  logic            sel_s;
  logic            sel_we_s;
  logic [7:0]      sel_addr_s;
  logic [7:0]      sel_wdata_s;
  logic            addr_bad_s;
  logic [4:0]      shift_last_s;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    if (req_i == 2'b11) begin
      sel_s = ~last_q;
    end else if (req_i[1]) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_we_s     = sel_s ? we_i[1]        : we_i[0];
    sel_addr_s   = sel_s ? addr_i[15:8]   : addr_i[7:0];
    sel_wdata_s  = sel_s ? wdata_i[15:8]  : wdata_i[7:0];
    addr_bad_s   = ({24'd0, sel_addr_s} >= DEPTH_U);
    // cnt 0 re-sends the op bit; frame bits follow on cnt 1..N, cs rises at N+1
    shift_last_s = we_q ? 5'd17 : 5'd9;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          state_d = addr_bad_s ? RESP : START;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = SHIFT_OUT;
      SHIFT_OUT: begin
        if (cnt_q == shift_last_s) begin
          state_d = we_q ? WAIT_DONE : WAIT_READY;
        end else begin
          state_d = SHIFT_OUT;
        end
      end
      WAIT_READY: begin
        if (spi_ready_i) begin
          state_d = SHIFT_IN;
        end else if (to_q == TO_LAST) begin
          state_d = RESP;
        end else begin
          state_d = WAIT_READY;
        end
      end
      SHIFT_IN: begin
        if (cnt_q == 5'd7) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = SHIFT_IN;
        end
      end
      WAIT_DONE: begin
        if (spi_op_done_i || (to_q == TO_LAST)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sh_d    = sh_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    rdata_d = 8'h00;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          gnt_d   = sel_s;
          last_d  = sel_s;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          frame_d = {sel_wdata_s, sel_addr_s};
          if (addr_bad_s) begin
            ack_d[sel_s] = 1'b1;
            err_d        = 1'b1;
          end else begin
            ack_d = 2'b00;
          end
        end else begin
          gnt_d = gnt_q;
        end
      end
      START: begin
        cs_n_d = 1'b0;
        mosi_d = we_q;
        cnt_d  = 5'd0;
      end
      SHIFT_OUT: begin
        if (cnt_q == 5'd0) begin
          mosi_d = we_q;
          cnt_d  = 5'd1;
        end else if (cnt_q == shift_last_s) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          cnt_d  = 5'd0;
          to_d   = '0;
        end else begin
          mosi_d  = frame_q[0];
          frame_d = {1'b0, frame_q[15:1]};
          cnt_d   = cnt_q + 5'd1;
        end
      end
      WAIT_READY: begin
        if (spi_ready_i) begin
          cnt_d = 5'd0;
        end else if (to_q == TO_LAST) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      SHIFT_IN: begin
        // miso arrives LSB first, so shift in from the top
        sh_d  = {spi_miso_i, sh_q[7:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd7) begin
          to_d = '0;
        end else begin
          to_d = to_q;
        end
      end
      WAIT_DONE: begin
        if (spi_op_done_i) begin
          ack_d[gnt_q] = 1'b1;
          rdata_d      = we_q ? 8'h00 : sh_q;
        end else if (to_q == TO_LAST) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RESP:    ack_d = 2'b00;
      default: ack_d = 2'b00;
    endcase
  end

  // Datapath and registered outputs; reset also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      frame_q <= 16'h0000;
      cnt_q   <= 5'd0;
      to_q    <= '0;
      sh_q    <= 8'h00;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: requester tasks issue directed ops,
// a slave model answers on the SPI pins, and a monitor checks every ack.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [1:0]  ack_o;
  logic [7:0]  rdata_o;
  logic        err_o;
  logic        busy_o;
  logic        spi_cs_n_o;
  logic        spi_mosi_o;
  logic        spi_ready_i;
  logic        spi_op_done_i;
  logic        spi_miso_i;

  spi_mem_arbiter #(.MEM_DEPTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .spi_cs_n_o(spi_cs_n_o), .spi_mosi_o(spi_mosi_o),
    .spi_ready_i(spi_ready_i), .spi_op_done_i(spi_op_done_i), .spi_miso_i(spi_miso_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    bit         err;
    bit         chk_rd;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  typedef struct {
    int          n;
    logic [17:0] bits;
  } frame_t;

  exp_t       exp_q[$];
  frame_t     frm_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         cyc = 0;
  int         issue_cyc[2];
  int         cs_falls = 0;
  bit         no_done = 1'b0;
  bit         abort_mode = 1'b0;
  logic [7:0] mem[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int p, input bit e, input bit c, input logic [7:0] d, input int l);
    exp_t x;
    x.port = p; x.err = e; x.chk_rd = c; x.rdata = d; x.lat = l;
    exp_q.push_back(x);
  endtask

  // Bit stream seen on mosi while cs is low: op, op again, then the frame LSB first.
  task automatic push_frame(input bit w, input logic [7:0] a, input logic [7:0] d);
    frame_t f;
    f.n    = w ? 18 : 10;
    f.bits = w ? {d, a, 1'b1, 1'b1} : {8'h00, a, 2'b00};
    frm_q.push_back(f);
  endtask

  // Raise a request at the current negedge and wait (bounded) for its ack.
  task automatic do_req(input int p, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input bit keep);
    bit got;
    req_i[p] = 1'b1;
    we_i[p]  = w;
    addr_i[8*p +: 8]  = a;
    wdata_i[8*p +: 8] = d;
    issue_cyc[p] = cyc;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ack_o[p]) got = 1'b1;
    end
    if (!got) check("ack_wait_timeout", 32'(p), 32'hFFFF_FFFF);
    if (!keep) req_i[p] = 1'b0;
  endtask

  // Monitor: every ack pulse is matched against the head of the scoreboard.
  initial begin
    exp_t x;
    int   p;
    forever begin
      @(negedge clk);
      if (ack_o != 2'b00) begin
        check("ack_onehot", 32'(ack_o == 2'b11), 32'd0);
        p = ack_o[1] ? 1 : 0;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("ack_port", 32'(p), 32'(x.port));
          check("ack_err", 32'(err_o), 32'(x.err));
          if (x.chk_rd) check("ack_rdata", 32'(rdata_o), 32'(x.rdata));
          if (x.lat != 0) check("ack_latency", 32'(cyc - issue_cyc[p]), 32'(x.lat));
        end
      end
    end
  end

  // Slave model: collects each frame, stores writes, answers reads.
  initial begin
    frame_t      f;
    logic [17:0] rx;
    int          n;
    logic [7:0]  rd;
    spi_ready_i = 1'b0; spi_op_done_i = 1'b0; spi_miso_i = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rx = '0; n = 0;
    forever begin
      @(negedge clk);
      if (!spi_cs_n_o) begin
        if (n == 0) cs_falls++;
        if (n < 18) rx[n] = spi_mosi_o;
        n++;
      end else if (n > 0) begin
        if (abort_mode) begin
          n = 0; rx = '0;
        end else begin
          if (frm_q.size() == 0) begin
            check("unexpected_frame", 32'(n), 32'd0);
          end else begin
            f = frm_q.pop_front();
            check("frame_len", 32'(n), 32'(f.n));
            check("frame_bits", 32'(rx), 32'(f.bits));
          end
          if (n == 18 && rx[0]) begin
            mem[rx[6:2]] = rx[17:10];
            if (!no_done) begin
              @(negedge clk); spi_op_done_i = 1'b1;
              @(negedge clk); spi_op_done_i = 1'b0;
            end
          end else if (n == 10 && !rx[0]) begin
            rd = mem[rx[6:2]];
            @(negedge clk); spi_ready_i = 1'b1;
            @(negedge clk); spi_ready_i = 1'b0;
            for (int k = 0; k < 8; k++) begin
              spi_miso_i = rd[k];
              @(negedge clk);
            end
            spi_miso_i = 1'b0;
            spi_op_done_i = 1'b1;
            @(negedge clk); spi_op_done_i = 1'b0;
          end
          n = 0; rx = '0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int falls0;
    rst = 1'b1; req_i = 2'b00; we_i = 2'b00; addr_i = 16'h0000; wdata_i = 16'h0000;
    issue_cyc[0] = 0; issue_cyc[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("rst_mosi", 32'(spi_mosi_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xA5 to 0x05 from port 0, read it back from port 1.
    push_exp(0, 1'b0, 1'b0, 8'h00, 22); push_frame(1'b1, 8'h05, 8'hA5);
    do_req(0, 1'b1, 8'h05, 8'hA5, 1'b0);
    repeat (2) @(negedge clk);
    push_exp(1, 1'b0, 1'b1, 8'hA5, 23); push_frame(1'b0, 8'h05, 8'h00);
    do_req(1, 1'b0, 8'h05, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // Both ports pending back to back: grants must go 0,1,0,1.
    push_exp(0, 1'b0, 1'b0, 8'h00, 0); push_frame(1'b1, 8'h01, 8'h11);
    push_exp(1, 1'b0, 1'b0, 8'h00, 0); push_frame(1'b1, 8'h02, 8'h22);
    push_exp(0, 1'b0, 1'b1, 8'h22, 0); push_frame(1'b0, 8'h02, 8'h00);
    push_exp(1, 1'b0, 1'b1, 8'h11, 0); push_frame(1'b0, 8'h01, 8'h00);
    fork
      begin do_req(0, 1'b1, 8'h01, 8'h11, 1'b1); do_req(0, 1'b0, 8'h02, 8'h00, 1'b0); end
      begin do_req(1, 1'b1, 8'h02, 8'h22, 1'b1); do_req(1, 1'b0, 8'h01, 8'h00, 1'b0); end
    join
    repeat (2) @(negedge clk);

    // Out-of-range address: immediate error ack, no frame.
    falls0 = cs_falls;
    push_exp(0, 1'b1, 1'b0, 8'h00, 1);
    do_req(0, 1'b0, 8'h20, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("bad_addr_no_cs", 32'(cs_falls), 32'(falls0));

    // Slave never completes: timeout error, then normal service resumes.
    no_done = 1'b1;
    push_exp(1, 1'b1, 1'b1, 8'h00, 84); push_frame(1'b1, 8'h03, 8'h33);
    do_req(1, 1'b1, 8'h03, 8'h33, 1'b0);
    no_done = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(0, 1'b0, 1'b1, 8'hA5, 23); push_frame(1'b0, 8'h05, 8'h00);
    do_req(0, 1'b0, 8'h05, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // Reset lands at T+8 of a write to 0x05: frame aborted, no ack.
    abort_mode = 1'b1;
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[7:0] = 8'h05; wdata_i[7:0] = 8'h5A;
    repeat (9) @(negedge clk);
    check("pre_rst_cs_low", 32'(spi_cs_n_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    req_i[0] = 1'b0;
    check("abort_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ack", 32'(ack_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    abort_mode = 1'b0;
    push_exp(1, 1'b0, 1'b1, 8'hA5, 23); push_frame(1'b0, 8'h05, 8'h00);
    do_req(1, 1'b0, 8'h05, 8'h00, 1'b0);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || frm_q.size() != 0); i++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("frames_empty", 32'(frm_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 32, number of valid slave memory addresses (0..MEM_DEPTH-1).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles waited for any slave response.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester request; bit i held high by requester i until its ack.
REQ-006 we  input  2  per-requester op; 1=write, 0=read; stable while req high.
REQ-007 addr  input  16  requester i address in [8i+7:8i]; stable while req high.
REQ-008 wdata  input  16  requester i write data in [8i+7:8i]; stable while req high.
REQ-009 ack  output  2  one-cycle completion pulse to requester i; at most one bit high per cycle.
REQ-010 rdata  output  8  read data; valid only in the ack cycle of a successful read.
REQ-011 err  output  1  error flag; valid only in an ack cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 spi_cs_n  output  1  slave chip select, active low, registered.
REQ-014 spi_mosi  output  1  serial data to slave, registered.
REQ-015 spi_ready  input  1  slave read-data-ready pulse.
REQ-016 spi_op_done  input  1  slave operation-complete pulse.
REQ-017 spi_miso  input  1  serial data from slave.

Function
REQ-018 States: IDLE, START, SHIFT_OUT, WAIT_READY, SHIFT_IN, WAIT_DONE, RESP.
REQ-019 Arbitration in IDLE only: one pending requester is granted; both pending -> the one not served last wins (round-robin pointer, reset value favours requester 0); pointer updates on grant.
REQ-020 Granted addr >= MEM_DEPTH -> no SPI frame; ack[i]=1, err=1 in the next cycle (RESP), then IDLE.
REQ-021 Valid grant latches we/addr/wdata, goes to START; edge T (START exit) registers spi_cs_n=0 and spi_mosi=op bit (1 write, 0 read); spi_mosi holds op through edge T+1.
REQ-022 SHIFT_OUT: frame bit j registered on spi_mosi at edge T+2+j, LSB first; write frame = {wdata,addr} (16 bits, addr[0] first); read frame = addr (8 bits).
REQ-023 spi_cs_n registered high at the edge after the last frame bit (T+18 write, T+10 read) and stays high until the next START.
REQ-024 Write: after SHIFT_OUT go to WAIT_DONE; spi_op_done sampled high (nominally edge T+20) -> RESP with ack[i]=1, err=0.
REQ-025 Read: after SHIFT_OUT go to WAIT_READY; spi_ready sampled high at edge E (nominally T+12) -> SHIFT_IN; spi_miso sampled at edges E+1..E+8 into rdata bit 0..7; then WAIT_DONE; spi_op_done -> RESP with ack[i]=1, err=0, rdata valid.
REQ-026 Timeout counter clears on entry to WAIT_READY/WAIT_DONE; TIMEOUT cycles without the awaited pulse -> RESP with err=1, rdata=0.
REQ-027 spi_ready or spi_op_done outside its wait state is ignored.
REQ-028 RESP lasts exactly one cycle, then IDLE; earliest next spi_cs_n fall is 2 cycles after RESP, guaranteeing slave returns to idle with cs high.
REQ-029 Request dropped before ack: transaction still completes; ack still pulses.

Reset
REQ-030 rst high: state IDLE, ack=0, rdata=0, err=0, busy=0, spi_cs_n=1, spi_mosi=0, round-robin pointer favours requester 0, counters cleared.
REQ-031 rst mid-frame aborts with no ack; spi_cs_n=1 at the next edge.

Verification
REQ-032 Requester 0 writes addr 0x05 data 0xA5 with slave model -> mosi shows op 1 then bits of 0x05, 0xA5 LSB first; ack[0]=1, err=0.
REQ-033 Requester 1 reads addr 0x05 after the write -> rdata=0xA5 in ack[1] cycle, err=0; cs high from T+10.
REQ-034 Both requesters pending continuously -> grants alternate 0,1,0,1; no back-to-back ack to the same port.
REQ-035 Read addr 0x20 (MEM_DEPTH=32) -> no cs fall, ack with err=1 one cycle after grant.
REQ-036 Slave model never pulses spi_op_done -> ack with err=1 after TIMEOUT=64 cycles in WAIT_DONE; next request serviced normally.
REQ-037 rst asserted at cycle T+8 of a write -> spi_cs_n=1, busy=0, no ack; a following read returns the slave's prior contents.
